// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e    frame FSM states (idle, data bits, parity bit, stop bit)
//   PS2_PFX_EXT    extended-key prefix byte
//   PS2_PFX_BREAK  key-release prefix byte
//   PS2_FRAME_LEN  bits per PS/2 frame (start, 8 data, parity, stop)
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0]  PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0]  PS2_PFX_BREAK = 8'hF0;
    localparam int unsigned PS2_FRAME_LEN = 11;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: two-flop synchroniser followed by a level filter for one
// asynchronous PS/2 line. The filtered output only follows the line after
// FILTER_LEN consecutive identical synchronised samples; it resets to 1 (idle).
//   clk        system clock
//   rst        synchronous reset, active-high
//   line_raw   raw asynchronous line
//   line_filt  synchronised, deglitched line
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_raw,
    output logic line_filt
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the filtered level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_raw};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_filt = filt_q;

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: receive-only PS/2 keyboard receiver. Deglitches PS2_CLK/PS2_DAT,
// deserialises 11-bit frames, and folds E0/F0 prefixes into single key events.
// Optional build macro: PS2_KEY_RX_PARITY_EN enables odd-parity checking;
// without it the parity bit is ignored.
//   i_clk        system clock (12 MHz)
//   i_rst        synchronous reset, active-high
//   i_ps2_clk    raw PS/2 clock
//   i_ps2_dat    raw PS/2 data
//   o_key_valid  one-cycle event pulse
//   o_key_code   scan code of last event (held)
//   o_key_break  last event was a release
//   o_key_ext    last event was extended
//   o_err        one-cycle framing / parity / timeout error pulse
//   o_busy       frame in progress
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 24000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_key_valid,
    output logic [7:0] o_key_code,
    output logic       o_key_break,
    output logic       o_key_ext,
    output logic       o_err,
    output logic       o_busy
);

    localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DATA_BITS = PS2_FRAME_LEN - 3;

    logic clk_filt, dat_filt;
    logic clk_prev_q;
    logic fall;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic [7:0]    code_q, code_d;
    logic          out_brk_q, out_brk_d, out_ext_q, out_ext_d;
    logic          frame_ok;
`ifdef PS2_KEY_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk       (i_clk),
        .rst       (i_rst),
        .line_raw  (i_ps2_clk),
        .line_filt (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk       (i_clk),
        .rst       (i_rst),
        .line_raw  (i_ps2_dat),
        .line_filt (dat_filt)
    );

    assign fall = clk_prev_q & ~clk_filt;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        code_d    = code_q;
        out_brk_d = out_brk_q;
        out_ext_d = out_ext_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        frame_ok  = 1'b0;
`ifdef PS2_KEY_RX_PARITY_EN
        par_d     = par_q;
`endif
        tmo_d     = (state_q == StIdle || fall) ? '0 : tmo_q + TW'(1);

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    if (!dat_filt) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (fall) begin
                    // LSB arrives first: shift in at the top.
                    shift_d   = {dat_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
`ifdef PS2_KEY_RX_PARITY_EN
                    par_d = dat_filt;
`endif
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
`ifdef PS2_KEY_RX_PARITY_EN
                    frame_ok = dat_filt & ps2_parity_ok(shift_q, par_q);
`else
                    frame_ok = dat_filt;
`endif
                    if (frame_ok) begin
                        if (shift_q == PS2_PFX_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_PFX_BREAK) begin
                            brk_d = 1'b1;
                        end else begin
                            valid_d   = 1'b1;
                            code_d    = shift_q;
                            out_brk_d = brk_q;
                            out_ext_d = ext_q;
                            ext_d     = 1'b0;
                            brk_d     = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end
        endcase

        // Abandon a stalled frame; prefix flags survive so a resent byte still folds.
        if (state_q != StIdle && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_prev_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
            out_brk_q  <= 1'b0;
            out_ext_q  <= 1'b0;
`ifdef PS2_KEY_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_prev_q <= clk_filt;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            code_q     <= code_d;
            out_brk_q  <= out_brk_d;
            out_ext_q  <= out_ext_d;
`ifdef PS2_KEY_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign o_key_valid = valid_q;
    assign o_key_code  = code_q;
    assign o_key_break = out_brk_q;
    assign o_key_ext   = out_ext_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: table-driven frame vectors plus hand sequences for timeout,
// glitch rejection, bad start bit and mid-frame reset.
module tb_ps2_key_rx;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TMO  = 300;
    localparam int          H    = 40;  // PS/2 half period in i_clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pclk = 1'b1;
    logic       pdat = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break, key_ext, err, busy;

    ps2_key_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (pclk),
        .i_ps2_dat   (pdat),
        .o_key_valid (key_valid),
        .o_key_code  (key_code),
        .o_key_break (key_break),
        .o_key_ext   (key_ext),
        .o_err       (err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int   n_valid = 0, n_err = 0, err_cyc = 0;
    int   wide_pulse = 0, both_pulse = 0;
    logic prev_valid = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (key_valid) n_valid++;
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
        if ((key_valid && prev_valid) || (err && prev_err)) wide_pulse++;
        if (key_valid && err) both_pulse++;
        prev_valid = key_valid;
        prev_err   = err;
    end

    int checks = 0, errors = 0;
    int last_fall_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            pdat = f[i];
            wait_cyc(H);
            pclk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(H);
            pclk = 1'b1;
        end
        pdat = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                              input logic bad_stop);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = (~^d) ^ bad_par;
        f[10]   = ~bad_stop;
        return f;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int nv0, ne0, dly;

        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
`ifdef PS2_KEY_RX_PARITY_EN
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 0, 1, 8'h75, 1'b1, 1'b1};
        vecs[8]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h75, 1'b1, 1'b1};
        vecs[9]  = '{8'h5A, 1'b1, 1'b0, 0, 1, 8'h75, 1'b1, 1'b1};
`else
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[8]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[9]  = '{8'h5A, 1'b1, 1'b0, 1, 0, 8'h5A, 1'b0, 1'b1};
`endif
        vecs[10] = '{8'h29, 1'b0, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0};
        vecs[11] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h29, 1'b0, 1'b0};
        vecs[12] = '{8'h33, 1'b0, 1'b1, 0, 1, 8'h29, 1'b0, 1'b0};
        vecs[13] = '{8'h29, 1'b0, 1'b0, 1, 0, 8'h29, 1'b0, 1'b0};

        // Reset values
        wait_cyc(5);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_break", key_break, 0);
        chk("rst_ext", key_ext, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(20);

        foreach (vecs[i]) begin
            nv0 = n_valid;
            ne0 = n_err;
            send_bits(mk_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop), 11);
            wait_cyc(20);
            chk($sformatf("v%0d_valid_cnt", i), n_valid - nv0, vecs[i].exp_valid);
            chk($sformatf("v%0d_err_cnt", i), n_err - ne0, vecs[i].exp_err);
            chk($sformatf("v%0d_code", i), key_code, vecs[i].exp_code);
            chk($sformatf("v%0d_break", i), key_break, vecs[i].exp_brk);
            chk($sformatf("v%0d_ext", i), key_ext, vecs[i].exp_ext);
            chk($sformatf("v%0d_busy", i), busy, 0);
        end

        // Timeout after 4 data bits; the pending F0 flag must survive it.
        send_bits(mk_frame(8'hF0, 1'b0, 1'b0), 11);
        wait_cyc(20);
        nv0 = n_valid;
        ne0 = n_err;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
        wait_cyc(4);
        chk("tmo_busy_mid", busy, 1);
        while (n_err == ne0 && cyc < last_fall_cyc + int'(TMO) + 200) wait_cyc(1);
        dly = err_cyc - last_fall_cyc;
        chk("tmo_err_cnt", n_err - ne0, 1);
        chk("tmo_delay_in_window", int'(dly >= int'(TMO) && dly <= int'(TMO + FLEN) + 6), 1);
        wait_cyc(2);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_no_valid", n_valid - nv0, 0);
        send_bits(mk_frame(8'h29, 1'b0, 1'b0), 11);
        wait_cyc(20);
        chk("tmo_next_valid", n_valid - nv0, 1);
        chk("tmo_next_code", key_code, 8'h29);
        chk("tmo_next_break", key_break, 1);
        chk("tmo_next_ext", key_ext, 0);

        // Glitches of 3 and FILTER_LEN-1 cycles on the idle clock line.
        nv0 = n_valid;
        ne0 = n_err;
        pclk = 1'b0;
        wait_cyc(3);
        pclk = 1'b1;
        wait_cyc(30);
        pclk = 1'b0;
        wait_cyc(FLEN - 1);
        pclk = 1'b1;
        wait_cyc(30);
        chk("glitch_err_cnt", n_err - ne0, 0);
        chk("glitch_valid_cnt", n_valid - nv0, 0);
        chk("glitch_busy", busy, 0);

        // Start bit of 1 is a framing error.
        ne0 = n_err;
        send_bits(11'h7FF, 1);
        wait_cyc(20);
        chk("badstart_err_cnt", n_err - ne0, 1);
        chk("badstart_busy", busy, 0);

        // Reset mid-frame with a pending F0.
        send_bits(mk_frame(8'hF0, 1'b0, 1'b0), 11);
        wait_cyc(20);
        nv0 = n_valid;
        ne0 = n_err;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 4);
        wait_cyc(4);
        chk("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("rstmid_valid", key_valid, 0);
        chk("rstmid_code", key_code, 0);
        chk("rstmid_break", key_break, 0);
        chk("rstmid_ext", key_ext, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_busy", busy, 0);
        wait_cyc(3 * H);
        chk("rstmid_no_valid", n_valid - nv0, 0);
        chk("rstmid_no_err", n_err - ne0, 0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
        wait_cyc(20);
        chk("rstmid_next_valid", n_valid - nv0, 1);
        chk("rstmid_next_code", key_code, 8'h1C);
        chk("rstmid_next_break", key_break, 0);

        chk("pulse_width_one", wide_pulse, 0);
        chk("valid_err_exclusive", both_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
